pwm_dac_out: RTL

//   Downstream output stage for the 8-bit sample generator: converts each sample into a

---
 rtl/pwm_dac_out.sv | 113 +++++++++++
 1 files changed

// File: rtl/pwm_dac_out.sv
// PWM output stage: samples enter a one-entry shadow register through valid/ready
// and are committed to the active duty only at a period wrap. Optional PWM_UNDERRUN_CNT_EN.
module pwm_dac_out #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 255,
    parameter int PRESCALE  = 1
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             pwm_out,
    output logic             period_strobe
`ifdef PWM_UNDERRUN_CNT_EN
    ,
    output logic [15:0]      underrun_count
`endif
);

    localparam int CNT_W = $clog2(MAX_COUNT + 1);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CMP_W = (WIDTH > CNT_W) ? WIDTH : CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNT);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             shadowFull_q, shadowFull_d;
    logic             pwm_q, pwm_d;
    logic             strobe_q, strobe_d;
    logic             tick;
    logic             wrap;
    logic             accept;

    assign sample_ready  = !shadowFull_q && !rst;
    assign accept        = sample_valid && sample_ready;
    assign pwm_out       = pwm_q;
    assign period_strobe = strobe_q;

    always_comb begin
        tick         = (pre_q == PRE_MAX);
        pre_d        = tick ? '0 : pre_q + PRE_W'(1);
        wrap         = tick && (cnt_q == CNT_MAX);
        cnt_d        = cnt_q;
        duty_d       = duty_q;
        shadow_d     = shadow_q;
        shadowFull_d = shadowFull_q;
        if (wrap) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // A sample accepted on the wrap edge lands in the shadow; it never bypasses to duty.
        if (wrap && shadowFull_q) begin
            duty_d       = shadow_q;
            shadowFull_d = 1'b0;
        end
        if (accept) begin
            shadow_d     = sample_in;
            shadowFull_d = 1'b1;
        end
        pwm_d    = (CMP_W'(cnt_q) < CMP_W'(duty_q));
        strobe_d = wrap;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            pre_q        <= '0;
            cnt_q        <= '0;
            duty_q       <= '0;
            shadow_q     <= '0;
            shadowFull_q <= 1'b0;
            pwm_q        <= 1'b0;
            strobe_q     <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            cnt_q        <= cnt_d;
            duty_q       <= duty_d;
            shadow_q     <= shadow_d;
            shadowFull_q <= shadowFull_d;
            pwm_q        <= pwm_d;
            strobe_q     <= strobe_d;
        end
    end

`ifdef PWM_UNDERRUN_CNT_EN
    // Counts wraps that found no fresh sample waiting; saturates instead of rolling over.
    logic [15:0] underrun_q, underrun_d;

    always_comb begin
        underrun_d = underrun_q;
        if (wrap && !shadowFull_q && (underrun_q != 16'hFFFF)) begin
            underrun_d = underrun_q + 16'd1;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            underrun_q <= '0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign underrun_count = underrun_q;
`else
    // Underrun bookkeeping is left out of this build.
`endif

endmodule
